// File: rtl/branch_target_unit.sv
// Branch/jump target unit: computes B/J/JALR targets and holds a direct-mapped BTB with 2-bit counters.
// Lookup answers one cycle after f_valid; training and the mispredict redirect land on the edge ending r_valid.
module branch_target_unit #(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            Rst,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_pc,
   output logic            p_valid,
   output logic            p_hit,
   output logic            p_taken,
   output logic [XLEN-1:0] p_target,
   input  logic            r_valid,
   input  logic [XLEN-1:0] r_pc,
   input  logic [31:0]     r_ins,
   input  logic            r_comp,
   input  logic [XLEN-1:0] r_comp_imm,
   input  logic [XLEN-1:0] r_rs1,
   input  logic            r_jal,
   input  logic            r_jalr,
   input  logic            r_branch,
   input  logic            r_cond,
   input  logic            r_pred_taken,
   input  logic [XLEN-1:0] r_pred_target,
   input  logic            flush_btb,
   output logic [XLEN-1:0] r_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 1;

   logic             btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
   logic [1:0]       btb_ctr    [BTB_ENTRIES];

   logic [XLEN-1:0]  imm_b, imm_j, imm_i, off, sum, fall, step;
   logic             jalr_sel, is_ctrl, act_taken, mispredict;
   logic [IDX_W-1:0] r_idx, f_idx;
   logic [TAG_W-1:0] r_tag, f_tag;
   logic             r_hit, f_hit;

   assign imm_b = {{(XLEN-12){r_ins[31]}}, r_ins[7], r_ins[30:25], r_ins[11:8], 1'b0};
   assign imm_j = {{(XLEN-20){r_ins[31]}}, r_ins[19:12], r_ins[20], r_ins[30:21], 1'b0};
   assign imm_i = {{(XLEN-12){r_ins[31]}}, r_ins[31:20]};

   // JAL wins over JALR, which wins over a branch, when several class bits are set.
   always_comb begin
      off = imm_b;
      if (r_jal)
         off = imm_j;
      else if (r_jalr)
         off = imm_i;
      if (r_comp)
         off = r_comp_imm;
   end

   assign jalr_sel = r_jalr & ~r_jal;
   assign sum      = (jalr_sel ? r_rs1 : r_pc) + off;
   assign r_target = jalr_sel ? {sum[XLEN-1:1], 1'b0} : sum;
   assign step     = r_comp ? XLEN'(2) : XLEN'(4);
   assign fall     = r_pc + step;

   assign is_ctrl    = r_jal | r_jalr | r_branch;
   assign act_taken  = r_jal | r_jalr | (r_branch & r_cond);
   assign mispredict = r_valid & ((act_taken != r_pred_taken) |
                                  (act_taken & r_pred_taken & (r_target != r_pred_target)));

   assign r_idx = r_pc[IDX_W:1];
   assign r_tag = r_pc[XLEN-1:IDX_W+1];
   assign f_idx = f_pc[IDX_W:1];
   assign f_tag = f_pc[XLEN-1:IDX_W+1];
   assign r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
   assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         p_valid        <= 1'b0;
         p_hit          <= 1'b0;
         p_taken        <= 1'b0;
         p_target       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         p_valid        <= f_valid;
         p_hit          <= f_valid & f_hit;
         p_taken        <= f_valid & f_hit & btb_ctr[f_idx][1];
         p_target       <= (f_valid & f_hit) ? btb_target[f_idx] : '0;
         redirect_valid <= mispredict;
         if (mispredict)
            redirect_pc <= act_taken ? r_target : fall;
      end
   end

   // Flush beats a same-cycle training write; non-control hits are killed to stop alias predictions.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'd1;
         end
      end else if (flush_btb) begin
         for (int i = 0; i < BTB_ENTRIES; i++)
            btb_valid[i] <= 1'b0;
      end else if (r_valid) begin
         if (is_ctrl) begin
            btb_valid[r_idx]  <= 1'b1;
            btb_tag[r_idx]    <= r_tag;
            btb_target[r_idx] <= r_target;
            if (!r_hit)
               btb_ctr[r_idx] <= act_taken ? 2'd2 : 2'd1;
            else if (act_taken && btb_ctr[r_idx] != 2'd3)
               btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
            else if (!act_taken && btb_ctr[r_idx] != 2'd0)
               btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
         end else if (r_hit) begin
            btb_valid[r_idx] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: per-cycle vectors feed a BTB reference model whose
// expected lookup/redirect results are queued and popped when the DUT responds.
module tb_branch_target_unit;
   logic        clk = 1'b0;
   logic        Rst = 1'b1;
   logic        f_valid, r_valid, r_comp, r_jal, r_jalr, r_branch, r_cond, r_pred_taken, flush_btb;
   logic [31:0] f_pc, r_pc, r_ins, r_comp_imm, r_rs1, r_pred_target;
   logic        p_valid, p_hit, p_taken, redirect_valid;
   logic [31:0] p_target, r_target, redirect_pc;

   always #5 clk = ~clk;

   branch_target_unit #(.XLEN(32), .BTB_ENTRIES(16)) dut (
      .clk(clk), .Rst(Rst),
      .f_valid(f_valid), .f_pc(f_pc),
      .p_valid(p_valid), .p_hit(p_hit), .p_taken(p_taken), .p_target(p_target),
      .r_valid(r_valid), .r_pc(r_pc), .r_ins(r_ins), .r_comp(r_comp), .r_comp_imm(r_comp_imm),
      .r_rs1(r_rs1), .r_jal(r_jal), .r_jalr(r_jalr), .r_branch(r_branch), .r_cond(r_cond),
      .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target), .flush_btb(flush_btb),
      .r_target(r_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic        fv;
      logic [31:0] fpc;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] ins;
      logic        comp;
      logic [31:0] cimm;
      logic [31:0] rs1;
      logic        jal;
      logic        jalr;
      logic        br;
      logic        cond;
      logic        ptk;
      logic [31:0] ptg;
      logic        flush;
      logic [31:0] tgt;
   } vec_t;

   typedef struct {
      logic        pv;
      logic        ph;
      logic        pt;
      logic [31:0] ptg;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   localparam logic [2:0] CJ = 3'b100, CR = 3'b010, CB = 3'b001, CN = 3'b000;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic        m_v   [16];
   logic [26:0] m_tag [16];
   logic [31:0] m_tgt [16];
   logic [1:0]  m_ctr [16];

   function automatic vec_t idle(input logic fv, input logic [31:0] fpc);
      vec_t v;
      v.fv = fv;    v.fpc = fpc;  v.rv = 1'b0;  v.rpc = '0;   v.ins = '0;
      v.comp = 1'b0; v.cimm = '0; v.rs1 = '0;   v.jal = 1'b0; v.jalr = 1'b0;
      v.br = 1'b0;  v.cond = 1'b0; v.ptk = 1'b0; v.ptg = '0;  v.flush = 1'b0; v.tgt = '0;
      return v;
   endfunction

   function automatic vec_t res(input logic [31:0] pc, input logic [31:0] ins, input logic [2:0] cls,
                                input logic cond, input logic ptk, input logic [31:0] ptg,
                                input logic [31:0] tgt, input logic fv, input logic [31:0] fpc);
      vec_t v;
      v = idle(fv, fpc);
      v.rv = 1'b1; v.rpc = pc; v.ins = ins;
      {v.jal, v.jalr, v.br} = cls;
      v.cond = cond; v.ptk = ptk; v.ptg = ptg; v.tgt = tgt;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'd1;
      end
      exp_q.delete();
   endtask

   // Drives one cycle of inputs, queues the expected response, then advances the model.
   task automatic drive(input vec_t v);
      exp_t e;
      int   idx;
      logic hit, ctrl, act;
      f_valid = v.fv; f_pc = v.fpc; r_valid = v.rv; r_pc = v.rpc; r_ins = v.ins;
      r_comp = v.comp; r_comp_imm = v.cimm; r_rs1 = v.rs1; r_jal = v.jal; r_jalr = v.jalr;
      r_branch = v.br; r_cond = v.cond; r_pred_taken = v.ptk; r_pred_target = v.ptg;
      flush_btb = v.flush;
      idx   = int'(v.fpc[4:1]);
      hit   = v.fv && m_v[idx] && (m_tag[idx] == v.fpc[31:5]);
      e.pv  = v.fv;
      e.ph  = hit;
      e.pt  = hit && m_ctr[idx][1];
      e.ptg = hit ? m_tgt[idx] : 32'h0;
      ctrl  = v.jal | v.jalr | v.br;
      act   = v.jal | v.jalr | (v.br & v.cond);
      e.rv  = v.rv && ((act != v.ptk) || (act && v.ptk && (v.tgt != v.ptg)));
      e.rpc = act ? v.tgt : (v.rpc + (v.comp ? 32'd2 : 32'd4));
      exp_q.push_back(e);
      idx = int'(v.rpc[4:1]);
      hit = m_v[idx] && (m_tag[idx] == v.rpc[31:5]);
      if (v.flush) begin
         for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      end else if (v.rv && ctrl) begin
         if (!hit)             m_ctr[idx] = act ? 2'd2 : 2'd1;
         else if (act)         m_ctr[idx] = (m_ctr[idx] == 2'd3) ? 2'd3 : m_ctr[idx] + 2'd1;
         else                  m_ctr[idx] = (m_ctr[idx] == 2'd0) ? 2'd0 : m_ctr[idx] - 2'd1;
         m_v[idx] = 1'b1; m_tag[idx] = v.rpc[31:5]; m_tgt[idx] = v.tgt;
      end else if (v.rv && hit) begin
         m_v[idx] = 1'b0;
      end
   endtask

   task automatic test_reset();
      f_valid = 0; f_pc = 0; r_valid = 0; r_pc = 0; r_ins = 0; r_comp = 0; r_comp_imm = 0;
      r_rs1 = 0; r_jal = 0; r_jalr = 0; r_branch = 0; r_cond = 0; r_pred_taken = 0;
      r_pred_target = 0; flush_btb = 0;
      Rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({p_valid, p_hit, p_taken} !== 3'b000 || p_target !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_lookup got v%b h%b t%b %h want all zero", p_valid, p_hit, p_taken, p_target);
      end
      n_vec++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_redirect got v%b pc %h want 0 00000000", redirect_valid, redirect_pc);
      end
      Rst = 1'b0;
   endtask

   task automatic test_targets();
      vec_t vs[$];
      vec_t v;
      exp_t e;
      vs.push_back(res(32'h200, 32'hFF9FF06F, CJ, 0, 1, 32'h1F8, 32'h1F8, 1, 32'h200));
      v = res(32'h344, 32'hFFF00067, CR, 0, 0, 32'h0, 32'h1000, 1, 32'h200);
      v.rs1 = 32'h1001;
      vs.push_back(v);
      vs.push_back(res(32'h100, 32'h00000863, CB, 1, 0, 32'h0, 32'h110, 1, 32'h344));
      v = res(32'h150, 32'h00000000, CB, 1, 1, 32'h14C, 32'h14C, 1, 32'h100);
      v.comp = 1'b1; v.cimm = 32'hFFFFFFFC;
      vs.push_back(v);
      vs.push_back(idle(1, 32'h100));
      vs.push_back(idle(0, 32'h100));
      foreach (vs[i]) begin
         drive(vs[i]);
         #1;
         if (vs[i].rv && (vs[i].jal | vs[i].jalr | vs[i].br)) begin
            n_vec++;
            if (r_target !== vs[i].tgt) begin
               n_bad++;
               $display("FAIL targets[%0d] r_target got %h want %h", i, r_target, vs[i].tgt);
            end
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if ({p_valid, p_hit, p_taken} !== {e.pv, e.ph, e.pt} || p_target !== e.ptg) begin
            n_bad++;
            $display("FAIL targets[%0d] lookup got v%b h%b t%b %h want v%b h%b t%b %h", i,
                     p_valid, p_hit, p_taken, p_target, e.pv, e.ph, e.pt, e.ptg);
         end
         n_vec++;
         if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.rpc)) begin
            n_bad++;
            $display("FAIL targets[%0d] redirect got %b %h want %b %h", i,
                     redirect_valid, redirect_pc, e.rv, e.rpc);
         end
      end
   endtask

   task automatic test_counters();
      vec_t vs[$];
      exp_t e;
      for (int k = 0; k < 4; k++)
         vs.push_back(res(32'h100, 32'h00000863, CB, 1, 1, 32'h110, 32'h110, 1, 32'h100));
      for (int k = 0; k < 2; k++)
         vs.push_back(res(32'h100, 32'h00000863, CB, 0, 1, 32'h110, 32'h110, 1, 32'h100));
      vs.push_back(idle(1, 32'h100));
      foreach (vs[i]) begin
         drive(vs[i]);
         #1;
         n_vec++;
         if (vs[i].rv && r_target !== vs[i].tgt) begin
            n_bad++;
            $display("FAIL counters[%0d] r_target got %h want %h", i, r_target, vs[i].tgt);
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if ({p_valid, p_hit, p_taken} !== {e.pv, e.ph, e.pt} || p_target !== e.ptg) begin
            n_bad++;
            $display("FAIL counters[%0d] lookup got v%b h%b t%b %h want v%b h%b t%b %h", i,
                     p_valid, p_hit, p_taken, p_target, e.pv, e.ph, e.pt, e.ptg);
         end
         n_vec++;
         if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.rpc)) begin
            n_bad++;
            $display("FAIL counters[%0d] redirect got %b %h want %b %h", i,
                     redirect_valid, redirect_pc, e.rv, e.rpc);
         end
      end
   endtask

   task automatic test_alias();
      vec_t vs[$];
      vec_t v;
      exp_t e;
      v = res(32'h100, 32'h00000013, CN, 0, 1, 32'h0, 32'h0, 1, 32'h100);
      v.comp = 1'b1;
      vs.push_back(v);
      vs.push_back(idle(1, 32'h100));
      vs.push_back(res(32'h350, 32'h00000013, CN, 0, 0, 32'h0, 32'h0, 1, 32'h150));
      vs.push_back(idle(1, 32'h150));
      foreach (vs[i]) begin
         drive(vs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if ({p_valid, p_hit, p_taken} !== {e.pv, e.ph, e.pt} || p_target !== e.ptg) begin
            n_bad++;
            $display("FAIL alias[%0d] lookup got v%b h%b t%b %h want v%b h%b t%b %h", i,
                     p_valid, p_hit, p_taken, p_target, e.pv, e.ph, e.pt, e.ptg);
         end
         n_vec++;
         if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.rpc)) begin
            n_bad++;
            $display("FAIL alias[%0d] redirect got %b %h want %b %h", i,
                     redirect_valid, redirect_pc, e.rv, e.rpc);
         end
      end
   endtask

   task automatic test_flush();
      vec_t vs[$];
      vec_t v;
      exp_t e;
      vs.push_back(res(32'h104, 32'h00000863, CB, 1, 0, 32'h0, 32'h114, 0, 32'h0));
      vs.push_back(res(32'h108, 32'hFF9FF06F, CJ, 0, 1, 32'h100, 32'h100, 1, 32'h104));
      v = res(32'h10C, 32'h00000863, CB, 1, 1, 32'h11C, 32'h11C, 1, 32'h108);
      v.flush = 1'b1;
      vs.push_back(v);
      vs.push_back(idle(1, 32'h104));
      vs.push_back(idle(1, 32'h108));
      vs.push_back(idle(1, 32'h10C));
      vs.push_back(idle(1, 32'h150));
      foreach (vs[i]) begin
         drive(vs[i]);
         #1;
         if (vs[i].rv) begin
            n_vec++;
            if (r_target !== vs[i].tgt) begin
               n_bad++;
               $display("FAIL flush[%0d] r_target got %h want %h", i, r_target, vs[i].tgt);
            end
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if ({p_valid, p_hit, p_taken} !== {e.pv, e.ph, e.pt} || p_target !== e.ptg) begin
            n_bad++;
            $display("FAIL flush[%0d] lookup got v%b h%b t%b %h want v%b h%b t%b %h", i,
                     p_valid, p_hit, p_taken, p_target, e.pv, e.ph, e.pt, e.ptg);
         end
         n_vec++;
         if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.rpc)) begin
            n_bad++;
            $display("FAIL flush[%0d] redirect got %b %h want %b %h", i,
                     redirect_valid, redirect_pc, e.rv, e.rpc);
         end
      end
   endtask

   task automatic test_async_reset();
      vec_t v;
      exp_t e;
      v = res(32'h344, 32'hFFF00067, CR, 0, 0, 32'h0, 32'h1000, 1, 32'h344);
      v.rs1 = 32'h1001;
      drive(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (redirect_valid !== e.rv || redirect_pc !== e.rpc || p_valid !== e.pv) begin
         n_bad++;
         $display("FAIL async_pre got rv%b pc %h pv%b want rv%b pc %h pv%b",
                  redirect_valid, redirect_pc, p_valid, e.rv, e.rpc, e.pv);
      end
      drive(idle(0, 32'h0));
      model_reset();
      Rst = 1'b1;
      #2;
      n_vec++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || p_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL async_rst got rv%b pc %h pv%b want 0 00000000 0",
                  redirect_valid, redirect_pc, p_valid);
      end
      @(posedge clk);
      #1;
      Rst = 1'b0;
      drive(idle(1, 32'h344));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({p_valid, p_hit, p_taken} !== {e.pv, e.ph, e.pt} || p_target !== e.ptg) begin
         n_bad++;
         $display("FAIL async_post lookup got v%b h%b t%b %h want v%b h%b t%b %h",
                  p_valid, p_hit, p_taken, p_target, e.pv, e.ph, e.pt, e.ptg);
      end
   endtask

   initial begin
      test_reset();
      test_targets();
      test_counters();
      test_alias();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
